// File: rtl/esp_dma_pkg.sv
// rtl/esp_dma_pkg.sv - shared constants and state types for the ESP DMA responder
package esp_dma_pkg;

    localparam logic [2:0] DMA_SIZE_DWORD = 3'b011;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_STREAM
    } rd_state_e;

    typedef enum logic {
        W_IDLE,
        W_STREAM
    } wr_state_e;

    localparam int ERR_RD_OOB = 0;
    localparam int ERR_WR_OOB = 1;
    localparam int ERR_SIZE   = 2;
    localparam int ERR_HOST   = 3;

endpackage

// File: rtl/esp_dma_responder_if.sv
// rtl/esp_dma_responder_if.sv - ESP DMA initiator/responder control and channel bundle
interface esp_dma_responder_if;

    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic [5:0]  dma_read_ctrl_data_user;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready;
    logic [63:0] dma_read_chnl_data;
    logic        dma_write_ctrl_valid;
    logic        dma_write_ctrl_ready;
    logic [31:0] dma_write_ctrl_data_index;
    logic [31:0] dma_write_ctrl_data_length;
    logic [2:0]  dma_write_ctrl_data_size;
    logic [5:0]  dma_write_ctrl_data_user;
    logic        dma_write_chnl_valid;
    logic        dma_write_chnl_ready;
    logic [63:0] dma_write_chnl_data;

    modport slave (
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
               dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_ctrl_data_user, dma_write_chnl_valid,
               dma_write_chnl_data,
        output dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
               dma_write_ctrl_ready, dma_write_chnl_ready
    );

    modport master (
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_ctrl_data_user, dma_read_chnl_ready,
               dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_ctrl_data_user, dma_write_chnl_valid,
               dma_write_chnl_data,
        input  dma_read_ctrl_ready, dma_read_chnl_valid, dma_read_chnl_data,
               dma_write_ctrl_ready, dma_write_chnl_ready
    );

endinterface

// File: rtl/esp_dma_resp_mem.sv
// rtl/esp_dma_resp_mem.sv - MEM_WORDS x 64 simple dual-port RAM, sync read on A, write on B
module esp_dma_resp_mem #(
    parameter int MEM_WORDS = 8192,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              en_a,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [63:0]       rdata_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [63:0]       wdata_b
);

    logic [63:0] mem [MEM_WORDS];

    // Read-before-write: a same-cycle write to addr_a is not seen until the next read.
    always_ff @(posedge clk) begin
        if (en_a) rdata_a <= mem[addr_a];
    end

    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= wdata_b;
    end

endmodule

// File: rtl/esp_dma_responder.sv
// rtl/esp_dma_responder.sv - ESP DMA memory responder with host backdoor
// Optional ESP_DMA_RESP_STALL_EN adds LFSR-driven channel stalls.
module esp_dma_responder
    import esp_dma_pkg::*;
#(
    parameter int          MEM_WORDS = 8192,
    parameter int          ADDR_W    = $clog2(MEM_WORDS),
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    esp_dma_responder_if.slave dma,
    input  logic               host_en,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_addr,
    input  logic [63:0]        host_wdata,
    output logic [63:0]        host_rdata,
    output logic               rd_busy,
    output logic               wr_busy,
    output logic [3:0]         err
);

    rd_state_e   rd_state, rd_state_n;
    wr_state_e   wr_state, wr_state_n;
    logic [31:0] rd_index, rd_len, rd_cnt, rd_addr;
    logic [31:0] wr_index, wr_len, wr_cnt, wr_addr;
    logic        rd_ctrl_hs, rd_beat_hs, rd_fetch, rd_show, rd_valid;
    logic        wr_ctrl_hs, wr_beat_hs, wr_take, wr_ready;
    logic        host_ok, host_pend;
    logic [63:0] host_q, mem_rdata, mem_wdata_b;
    logic        mem_en_a, mem_we_b;
    logic [ADDR_W-1:0] mem_addr_a, mem_addr_b;
    logic        unused_ok;

    assign rd_busy    = (rd_state != R_IDLE);
    assign wr_busy    = (wr_state != W_IDLE);
    assign rd_ctrl_hs = !rd_busy && dma.dma_read_ctrl_valid;
    assign rd_beat_hs = rd_valid && dma.dma_read_chnl_ready;
    assign wr_ctrl_hs = !wr_busy && dma.dma_write_ctrl_valid;
    assign wr_beat_hs = wr_ready && dma.dma_write_chnl_valid;

    assign dma.dma_read_ctrl_ready  = !rd_busy;
    assign dma.dma_write_ctrl_ready = !wr_busy;
    assign dma.dma_read_chnl_valid  = rd_valid;
    assign dma.dma_read_chnl_data   = (rd_state == R_STREAM) ? mem_rdata : '0;
    assign dma.dma_write_chnl_ready = wr_ready;
    assign unused_ok = ^{dma.dma_read_ctrl_data_user, dma.dma_write_ctrl_data_user, LFSR_SEED};

`ifdef ESP_DMA_RESP_STALL_EN
    logic [15:0] lfsr;
    logic        rd_presented;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr         <= LFSR_SEED;
            rd_presented <= 1'b0;
        end else begin
            lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            rd_presented <= rd_valid && !dma.dma_read_chnl_ready;
        end
    end

    // A beat already on the bus stays up; only a fresh presentation may be held back.
    assign rd_show = !lfsr[0] || rd_presented;
    assign wr_take = !lfsr[1];
`else
    assign rd_show = 1'b1;
    assign wr_take = 1'b1;
`endif

    always_comb begin
        rd_state_n = rd_state;
        rd_fetch   = 1'b0;
        rd_addr    = rd_index + rd_cnt;
        rd_valid   = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (rd_ctrl_hs && dma.dma_read_ctrl_data_length != 32'd0) rd_state_n = R_FETCH;
            end
            R_FETCH: begin
                rd_fetch   = 1'b1;
                rd_state_n = R_STREAM;
            end
            R_STREAM: begin
                rd_valid = rd_show;
                // Prefetch the next word on every accepted beat for back-to-back streaming.
                if (rd_show && dma.dma_read_chnl_ready) begin
                    if (rd_cnt + 32'd1 == rd_len) begin
                        rd_state_n = R_IDLE;
                    end else begin
                        rd_fetch = 1'b1;
                        rd_addr  = rd_index + rd_cnt + 32'd1;
                    end
                end
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= R_IDLE;
            rd_index <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
        end else begin
            rd_state <= rd_state_n;
            if (rd_ctrl_hs) begin
                rd_index <= dma.dma_read_ctrl_data_index;
                rd_len   <= dma.dma_read_ctrl_data_length;
                rd_cnt   <= '0;
            end else if (rd_beat_hs) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        wr_state_n = wr_state;
        wr_ready   = 1'b0;
        wr_addr    = wr_index + wr_cnt;
        case (wr_state)
            W_IDLE: begin
                if (wr_ctrl_hs && dma.dma_write_ctrl_data_length != 32'd0) wr_state_n = W_STREAM;
            end
            W_STREAM: begin
                wr_ready = wr_take;
                if (wr_take && dma.dma_write_chnl_valid && wr_cnt + 32'd1 == wr_len)
                    wr_state_n = W_IDLE;
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= W_IDLE;
            wr_index <= '0;
            wr_len   <= '0;
            wr_cnt   <= '0;
        end else begin
            wr_state <= wr_state_n;
            if (wr_ctrl_hs) begin
                wr_index <= dma.dma_write_ctrl_data_index;
                wr_len   <= dma.dma_write_ctrl_data_length;
                wr_cnt   <= '0;
            end else if (wr_beat_hs) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

    // Host shares port A only while the read engine is idle, so rd_fetch never collides.
    assign host_ok     = host_en && !rd_busy && !wr_busy;
    assign mem_en_a    = rd_fetch || (host_ok && !host_we);
    assign mem_addr_a  = rd_fetch ? rd_addr[ADDR_W-1:0] : host_addr;
    assign mem_we_b    = wr_beat_hs || (host_ok && host_we);
    assign mem_addr_b  = wr_beat_hs ? wr_addr[ADDR_W-1:0] : host_addr;
    assign mem_wdata_b = wr_beat_hs ? dma.dma_write_chnl_data : host_wdata;
    assign host_rdata  = host_pend ? mem_rdata : host_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_pend <= 1'b0;
            host_q    <= '0;
            err       <= '0;
        end else begin
            host_pend <= host_ok && !host_we;
            if (host_pend) host_q <= mem_rdata;
            err[ERR_RD_OOB] <= err[ERR_RD_OOB] | (rd_fetch && rd_addr >= 32'(MEM_WORDS));
            err[ERR_WR_OOB] <= err[ERR_WR_OOB] | (wr_beat_hs && wr_addr >= 32'(MEM_WORDS));
            err[ERR_SIZE]   <= err[ERR_SIZE]
                             | (rd_ctrl_hs && dma.dma_read_ctrl_data_size != DMA_SIZE_DWORD)
                             | (wr_ctrl_hs && dma.dma_write_ctrl_data_size != DMA_SIZE_DWORD);
            err[ERR_HOST]   <= err[ERR_HOST] | (host_en && (rd_busy || wr_busy));
        end
    end

    esp_dma_resp_mem #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .en_a    (mem_en_a),
        .addr_a  (mem_addr_a),
        .rdata_a (mem_rdata),
        .we_b    (mem_we_b),
        .addr_b  (mem_addr_b),
        .wdata_b (mem_wdata_b)
    );

endmodule

// File: tb/tb_esp_dma_responder.sv
// tb/tb_esp_dma_responder.sv - self-checking bench for esp_dma_responder
module tb_esp_dma_responder;

    localparam int          MW   = 8192;
    localparam logic [31:0] MASK = 32'(MW - 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        host_en, host_we;
    logic [12:0] host_addr;
    logic [63:0] host_wdata, host_rdata;
    logic        rd_busy, wr_busy;
    logic [3:0]  err;

    always #5 clk = ~clk;

    esp_dma_responder_if dma();

    esp_dma_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dma        (dma),
        .host_en    (host_en),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .rd_busy    (rd_busy),
        .wr_busy    (wr_busy),
        .err        (err)
    );

    logic [63:0] model_mem [MW];
    logic [63:0] wbuf [64];
    logic [3:0]  model_err;
    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] idx;
        logic [31:0] len;
        logic [2:0]  size;
        int          mode;
        logic [3:0]  exp_err;
    } vec_t;
    vec_t vecs[9];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        dma.dma_read_ctrl_valid  = 1'b0;
        dma.dma_read_chnl_ready  = 1'b0;
        dma.dma_write_ctrl_valid = 1'b0;
        dma.dma_write_chnl_valid = 1'b0;
        host_en = 1'b0;
        host_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic host_rd(input logic [12:0] a, output logic [63:0] d);
        @(negedge clk);
        host_en = 1'b1; host_we = 1'b0; host_addr = a;
        @(negedge clk);
        host_en = 1'b0;
        d = host_rdata;
    endtask

    task automatic do_read(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] size,
                           input int mode, output int nbeats, output int bad_beats,
                           output int first_lat, output int unstable, output logic busy_after);
        int cyc, budget;
        logic [63:0] prev;
        logic prev_stall, r;
        logic [3:0] pat;
        logic [31:0] a;
        pat = 4'b1001;
        nbeats = 0; bad_beats = 0; first_lat = -1; unstable = 0; prev_stall = 1'b0; prev = '0;
        @(negedge clk);
        dma.dma_read_ctrl_valid       = 1'b1;
        dma.dma_read_ctrl_data_index  = idx;
        dma.dma_read_ctrl_data_length = len;
        dma.dma_read_ctrl_data_size   = size;
        dma.dma_read_ctrl_data_user   = 6'($urandom);
        chk("rd_ctrl_ready_idle", 64'(dma.dma_read_ctrl_ready), 64'd1);
        @(negedge clk);
        dma.dma_read_ctrl_valid = 1'b0;
        cyc = 1;
        budget = int'(len) * 8 + 10;
        while ((nbeats < int'(len) || len == 0) && cyc < budget) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 4] : 1'($urandom_range(0, 1));
            dma.dma_read_chnl_ready = r;
            if (dma.dma_read_chnl_valid) begin
                if (first_lat < 0) first_lat = cyc;
                if (prev_stall && dma.dma_read_chnl_data !== prev) unstable++;
                if (r) begin
                    a = idx + 32'(nbeats);
                    if (dma.dma_read_chnl_data !== model_mem[a & MASK]) bad_beats++;
                    nbeats++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev = dma.dma_read_chnl_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        dma.dma_read_chnl_ready = 1'b0;
        busy_after = rd_busy;
    endtask

    task automatic do_write(input logic [31:0] idx, input logic [31:0] len, input logic [2:0] size,
                            input int gaps, output int nbeats, output logic busy_after,
                            output logic ready_seen);
        int k, cyc;
        logic v;
        logic [31:0] a;
        @(negedge clk);
        dma.dma_write_ctrl_valid       = 1'b1;
        dma.dma_write_ctrl_data_index  = idx;
        dma.dma_write_ctrl_data_length = len;
        dma.dma_write_ctrl_data_size   = size;
        dma.dma_write_ctrl_data_user   = 6'($urandom);
        chk("wr_ctrl_ready_idle", 64'(dma.dma_write_ctrl_ready), 64'd1);
        @(negedge clk);
        dma.dma_write_ctrl_valid = 1'b0;
        ready_seen = dma.dma_write_chnl_ready;
        k = 0; cyc = 0;
        while (k < int'(len) && cyc < int'(len) * 8 + 10) begin
            v = (gaps != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            dma.dma_write_chnl_valid = v;
            dma.dma_write_chnl_data  = wbuf[k];
            if (v && dma.dma_write_chnl_ready) begin
                a = idx + 32'(k);
                model_mem[a & MASK] = wbuf[k];
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        dma.dma_write_chnl_valid = 1'b0;
        nbeats = k;
        busy_after = wr_busy;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, bb, fl, un;
        logic busy, rdy;
        logic [63:0] d, h;
        logic [31:0] idx, len, a;
        logic [2:0] size;
        bit is_wr;
        int sel;

        dma.dma_read_ctrl_valid = 1'b0;  dma.dma_read_ctrl_data_index = '0;
        dma.dma_read_ctrl_data_length = '0; dma.dma_read_ctrl_data_size = 3'b011;
        dma.dma_read_ctrl_data_user = '0; dma.dma_read_chnl_ready = 1'b0;
        dma.dma_write_ctrl_valid = 1'b0; dma.dma_write_ctrl_data_index = '0;
        dma.dma_write_ctrl_data_length = '0; dma.dma_write_ctrl_data_size = 3'b011;
        dma.dma_write_ctrl_data_user = '0; dma.dma_write_chnl_valid = 1'b0;
        dma.dma_write_chnl_data = '0;
        host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;

        apply_reset();
        chk("rst_rd_ctrl_ready", 64'(dma.dma_read_ctrl_ready), 64'd1);
        chk("rst_wr_ctrl_ready", 64'(dma.dma_write_ctrl_ready), 64'd1);
        chk("rst_rd_chnl_valid", 64'(dma.dma_read_chnl_valid), 64'd0);
        chk("rst_rd_chnl_data", dma.dma_read_chnl_data, 64'd0);
        chk("rst_wr_chnl_ready", 64'(dma.dma_write_chnl_ready), 64'd0);
        chk("rst_host_rdata", host_rdata, 64'd0);
        chk("rst_busy", {62'd0, rd_busy, wr_busy}, 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        for (int i = 0; i < MW; i++) begin
            @(negedge clk);
            host_en = 1'b1; host_we = 1'b1; host_addr = 13'(i);
            host_wdata = (i < 8) ? 64'(i * 'h11) : {$urandom, $urandom};
            model_mem[i] = host_wdata;
        end
        @(negedge clk);
        host_en = 1'b0; host_we = 1'b0;
        host_rd(13'd3, d);    chk("host_rd_3", d, 64'h33);
        host_rd(13'd8191, d); chk("host_rd_top", d, model_mem[8191]);

        vecs[0] = '{1'b0, 32'd0,          32'd8, 3'b011, 0, 4'b0000};
        vecs[1] = '{1'b0, 32'd16,         32'd6, 3'b011, 1, 4'b0000};
        vecs[2] = '{1'b1, 32'd100,        32'd3, 3'b011, 0, 4'b0000};
        vecs[3] = '{1'b0, 32'd8190,       32'd4, 3'b011, 0, 4'b0001};
        vecs[4] = '{1'b0, 32'd0,          32'd0, 3'b010, 0, 4'b0100};
        vecs[5] = '{1'b1, 32'd8191,       32'd2, 3'b011, 0, 4'b0010};
        vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd2, 3'b011, 1, 4'b0001};
        vecs[7] = '{1'b1, 32'd40,         32'd0, 3'b111, 0, 4'b0100};
        vecs[8] = '{1'b0, 32'd200,        32'd5, 3'b011, 2, 4'b0000};

        for (int v = 0; v < 9; v++) begin
            apply_reset();
            if (vecs[v].is_wr) begin
                for (int k = 0; k < 64; k++) wbuf[k] = {$urandom, $urandom};
                do_write(vecs[v].idx, vecs[v].len, vecs[v].size, vecs[v].mode, nb, busy, rdy);
                chk($sformatf("vec%0d_wr_beats", v), 64'(nb), 64'(vecs[v].len));
                chk($sformatf("vec%0d_wr_busy_after", v), 64'(busy), 64'd0);
                if (vecs[v].len == 0) chk($sformatf("vec%0d_wr_chnl_ready", v), 64'(rdy), 64'd0);
                for (int k = 0; k < int'(vecs[v].len); k++) begin
                    a = vecs[v].idx + 32'(k);
                    host_rd(13'(a & MASK), d);
                    chk($sformatf("vec%0d_readback%0d", v, k), d, wbuf[k]);
                end
            end else begin
                do_read(vecs[v].idx, vecs[v].len, vecs[v].size, vecs[v].mode, nb, bb, fl, un, busy);
                chk($sformatf("vec%0d_rd_beats", v), 64'(nb), 64'(vecs[v].len));
                chk($sformatf("vec%0d_rd_data", v), 64'(bb), 64'd0);
                chk($sformatf("vec%0d_rd_stable", v), 64'(un), 64'd0);
                chk($sformatf("vec%0d_rd_busy_after", v), 64'(busy), 64'd0);
                chk($sformatf("vec%0d_rd_ctrl_ready_after", v), 64'(dma.dma_read_ctrl_ready), 64'd1);
                if (v == 0) chk("vec0_first_latency", 64'(fl), 64'd2);
            end
            chk($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
        end

        apply_reset();
        host_rd(13'd301, h);
        fork
            do_read(32'd300, 32'd6, 3'b011, 0, nb, bb, fl, un, busy);
            begin
                repeat (3) @(negedge clk);
                host_en = 1'b1; host_we = 1'b1; host_addr = 13'd302; host_wdata = ~model_mem[302];
                @(negedge clk);
                host_we = 1'b0; host_addr = 13'd10;
                @(negedge clk);
                host_en = 1'b0;
            end
        join
        chk("conflict_beats", 64'(nb), 64'd6);
        chk("conflict_data", 64'(bb), 64'd0);
        chk("conflict_err", 64'(err), 64'b1000);
        chk("conflict_rdata_held", host_rdata, model_mem[301]);
        host_rd(13'd302, d);
        chk("conflict_mem_unchanged", d, model_mem[302]);

        apply_reset();
        model_err = '0;
        for (int it = 0; it < 30; it++) begin
            is_wr = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 3);
            idx = (sel < 2) ? 32'($urandom_range(0, MW - 1))
                : (sel == 2) ? 32'(MW - 1 - $urandom_range(0, 6)) : $urandom;
            len  = 32'($urandom_range(0, 10));
            size = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b011;
            if (size != 3'b011) model_err[2] = 1'b1;
            for (int i = 0; i < int'(len); i++) begin
                a = idx + 32'(i);
                if (a >= 32'(MW)) model_err[is_wr ? 1 : 0] = 1'b1;
            end
            if (is_wr) begin
                for (int k = 0; k < 64; k++) wbuf[k] = {$urandom, $urandom};
                do_write(idx, len, size, 1, nb, busy, rdy);
                chk($sformatf("rand%0d_wr_beats", it), 64'(nb), 64'(len));
                chk($sformatf("rand%0d_wr_busy", it), 64'(busy), 64'd0);
            end else begin
                do_read(idx, len, size, 2, nb, bb, fl, un, busy);
                chk($sformatf("rand%0d_rd_beats", it), 64'(nb), 64'(len));
                chk($sformatf("rand%0d_rd_data", it), 64'(bb), 64'd0);
                chk($sformatf("rand%0d_rd_stable", it), 64'(un), 64'd0);
                chk($sformatf("rand%0d_rd_busy", it), 64'(busy), 64'd0);
            end
            chk($sformatf("rand%0d_err", it), 64'(err), 64'(model_err));
        end

        for (int i = 0; i < 16; i++) begin
            a = 32'($urandom_range(0, MW - 1));
            host_rd(13'(a), d);
            chk($sformatf("final_readback_%0d", a), d, model_mem[a]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
